spram_arbiter: RTL and testbench
================================

// Module: spram_arbiter
// PURPOSE
//  Shares one single-port RAM (1-cycle registered read; rdata held during writes) among N_REQ requesters.
//  Round-robin arbitration with a valid/ready request and a response strobe carrying the winner's ID.
//  Sits between the TPU load/store agents (host DMA, weight fetch, activation write-back) and the RAM macro.
// PARAMETERS
//  BIT_WIDTH      32  bits per RAM element
//  RAM_WIDTH      16  elements per RAM word
//  RAM_ADDR_BITS  10  RAM address width; depth = 2**RAM_ADDR_BITS
//  N_REQ           3  number of requesters, >=2; ID_W = $clog2(N_REQ)
// PORTS
//  clk        in   1                               clock, all logic on rising edge
//  rst_n      in   1                               asynchronous active-low reset
//  req_valid  in   [N_REQ]                         requester i has a pending access
//  req_we     in   [N_REQ]                         1=write, 0=read
//  req_addr   in   [N_REQ][RAM_ADDR_BITS]          word address
//  req_wdata  in   [N_REQ][RAM_WIDTH][BIT_WIDTH]   write data
//  req_ready  out  [N_REQ]                         one-hot grant; access accepted when valid&ready
//  rsp_valid  out  1                               read data valid this cycle
//  rsp_id     out  ID_W                            requester that issued the read
//  rsp_data   out  [RAM_WIDTH][BIT_WIDTH]          read data (= ram_rdata)
//  init_done  out  1                               arbiter is serving requests
//  ram_we     out  1                               RAM write enable
//  ram_addr   out  RAM_ADDR_BITS                   RAM address
//  ram_wdata  out  [RAM_WIDTH][BIT_WIDTH]          RAM write data
//  ram_rdata  in   [RAM_WIDTH][BIT_WIDTH]          RAM read data
// BEHAVIOUR
//  Reset values: req_ready=0, rsp_valid=0, rsp_id=0, ram_we=0, ram_addr=0, ram_wdata=0, rr_ptr=0, init_done=0.
//  States: CLEAR (with macro only) -> SERVE. SERVE is never left except by reset.
//  SERVE arbitration (combinational):
//   - Winner = first i with req_valid[i], searching upward from rr_ptr with wrap.
//   - req_ready = onehot(winner); all zero when no request or not SERVE.
//   - ram_we/ram_addr/ram_wdata are driven combinationally from the winner.
//   - With no winner: ram_we=0 and ram_addr holds its last value (registered copy).
//  rr_ptr update: on each grant, rr_ptr <= winner+1, wrapping N_REQ-1 -> 0; unchanged when idle.
//  Read latency 1:
//   - A read accepted in cycle t gives rsp_valid=1, rsp_id=winner and rsp_data=ram_rdata in cycle t+1.
//   - rsp_valid=0 after writes and idle cycles. Back-to-back reads give one response per cycle.
//  Writes: no response. A read of the same address in the next cycle returns the new data.
//  One access per cycle total; losers keep valid/addr/data stable until ready (requester rule; assert in bench).
//  Reset mid-operation: in-flight response discarded, rsp_valid=0, rr_ptr=0, FSM re-enters its first state.
// CONFIGURATION
//  SPRAM_ARB_CLEAR_EN defined:
//   - After reset the FSM is in CLEAR and writes zero to addresses 0..2**RAM_ADDR_BITS-1, one per cycle.
//   - req_ready=0 during CLEAR.
//   - In the cycle after the last address: SERVE, init_done=1.
//  SPRAM_ARB_CLEAR_EN undefined:
//   - No CLEAR state; SERVE and init_done=1 from the first clock edge after reset release.
// STRUCTURE
//  Package spram_arb_pkg holds:
//   - typedef state_e {CLEAR, SERVE}
//   - ram_word_t (packed [RAM_WIDTH][BIT_WIDTH]) and the ID_W helper function.
//  Sub-module rr_arbiter (N_REQ, req vector + pointer -> one-hot grant + index), purely combinational.
//  Top holds the FSM, clear counter, rr_ptr and response pipeline register.
// TESTING (RAM model with 1-cycle read attached; N_REQ=3, RAM_ADDR_BITS=4 for speed)
//  1 Write then read: req0 writes 0xA5 to addr 3, then req0 reads addr 3 -> rsp_valid next cycle, rsp_id=0, data=0xA5.
//  2 Round robin: all three read every cycle -> grants 0,1,2,0,1,2; rsp_id follows one cycle later.
//  3 Mixed/idle: req1 write addr 5 then req2 read addr 5 back-to-back -> req2 gets new data;
//    idle cycle in between -> rsp_valid=0, rr_ptr unchanged.
//  4 Reset mid-read: assert rst_n=0 in the cycle after a read accept -> rsp_valid=0 immediately, req_ready=0.
//  5 CLEAR_EN: preload RAM with 0xFF -> req_ready=0 and init_done=0 for 16 cycles, then all addresses read 0.
//  6 Without macro -> init_done=1 one edge after reset release; req0 granted that cycle.

Source files
------------

// File: rtl/spram_arb_pkg.sv
// Shared types and helpers for the single-port RAM arbiter.
//   state_e     : arbiter FSM states (CLEAR is used only when SPRAM_ARB_CLEAR_EN is defined)
//   ram_word_t  : one RAM word at the default geometry (16 x 32-bit elements)
//   id_width()  : width of a requester index for a given requester count
package spram_arb_pkg;

  localparam int DEF_BIT_WIDTH = 32;
  localparam int DEF_RAM_WIDTH = 16;

  typedef enum logic {
    CLEAR = 1'b0,
    SERVE = 1'b1
  } state_e;

  typedef logic [DEF_RAM_WIDTH-1:0][DEF_BIT_WIDTH-1:0] ram_word_t;

  // A single requester still needs a 1-bit ID field.
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spram_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
//   req  : request vector
//   ptr  : highest-priority index this cycle
//   gnt  : one-hot grant (zero when no request)
//   idx  : index of the granted requester
//   any  : at least one request present
module rr_arbiter #(
  parameter int N_REQ = 3,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  // Walk offsets from farthest to nearest so the nearest requester at or
  // above ptr (with wrap) is the last one written and therefore wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      if (req[(int'(ptr) + off) % N_REQ]) begin
        idx = ID_W'((int'(ptr) + off) % N_REQ);
        any = 1'b1;
      end
    end
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/spram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM (1-cycle registered read)
// among N_REQ requesters.
// Optional build macro: SPRAM_ARB_CLEAR_EN -- zero the whole RAM after reset
// before serving requests.
// Ports:
//   clk, rst_n                      clock / async active-low reset
//   req_valid/we/addr/wdata         per-requester access request
//   req_ready                       one-hot grant (accepted when valid&ready)
//   rsp_valid/rsp_id/rsp_data       read response, one cycle after accept
//   init_done                       arbiter is serving requests
//   ram_we/ram_addr/ram_wdata       RAM command (combinational from winner)
//   ram_rdata                       RAM read data
module spram_arbiter
  import spram_arb_pkg::*;
#(
  parameter int BIT_WIDTH     = DEF_BIT_WIDTH,
  parameter int RAM_WIDTH     = DEF_RAM_WIDTH,
  parameter int RAM_ADDR_BITS = 10,
  parameter int N_REQ         = 3,
  localparam int ID_W         = id_width(N_REQ)
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic [N_REQ-1:0]                               req_valid,
  input  logic [N_REQ-1:0]                               req_we,
  input  logic [N_REQ-1:0][RAM_ADDR_BITS-1:0]            req_addr,
  input  logic [N_REQ-1:0][RAM_WIDTH-1:0][BIT_WIDTH-1:0] req_wdata,
  output logic [N_REQ-1:0]                               req_ready,
  output logic                                           rsp_valid,
  output logic [ID_W-1:0]                                rsp_id,
  output logic [RAM_WIDTH-1:0][BIT_WIDTH-1:0]            rsp_data,
  output logic                                           init_done,
  output logic                                           ram_we,
  output logic [RAM_ADDR_BITS-1:0]                       ram_addr,
  output logic [RAM_WIDTH-1:0][BIT_WIDTH-1:0]            ram_wdata,
  input  logic [RAM_WIDTH-1:0][BIT_WIDTH-1:0]            ram_rdata
);

  state_e                   state_q, state_d;
  logic [ID_W-1:0]          rr_ptr;
  logic [RAM_ADDR_BITS-1:0] addr_q;
  logic [N_REQ-1:0]         gnt;
  logic [ID_W-1:0]          win;
  logic                     any;
  logic                     grant;
  logic [RAM_ADDR_BITS-1:0] clr_cnt;
  logic                     clr_act;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (win),
    .any (any)
  );

`ifdef SPRAM_ARB_CLEAR_EN
  localparam state_e RST_STATE = CLEAR;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                clr_cnt <= '0;
    else if (state_q == CLEAR) clr_cnt <= clr_cnt + 1'b1;
  end

  // Gated by rst_n so the RAM sees no write while reset is held.
  assign clr_act = (state_q == CLEAR) && rst_n;
`else
  localparam state_e RST_STATE = SERVE;

  assign clr_cnt = '0;
  assign clr_act = 1'b0;
`endif

  // init_done is the registered "in SERVE" flag and gates every grant.
  assign grant    = init_done && any;
  assign rsp_data = ram_rdata;

  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (clr_act && (&clr_cnt)) state_d = SERVE;
      SERVE:   state_d = SERVE;
      default: state_d = RST_STATE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    ram_we    = 1'b0;
    ram_addr  = addr_q;
    ram_wdata = '0;
    if (clr_act) begin
      ram_we   = 1'b1;
      ram_addr = clr_cnt;
    end else if (grant) begin
      req_ready = gnt;
      ram_we    = req_we[win];
      ram_addr  = req_addr[win];
      ram_wdata = req_wdata[win];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RST_STATE;
      init_done <= 1'b0;
      rr_ptr    <= '0;
      addr_q    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
    end else begin
      state_q   <= state_d;
      init_done <= (state_d == SERVE);
      addr_q    <= ram_addr;
      rsp_valid <= grant && !req_we[win];
      if (grant) begin
        rr_ptr <= (win == ID_W'(N_REQ - 1)) ? '0 : win + 1'b1;
        if (!req_we[win]) rsp_id <= win;
      end
    end
  end

endmodule

// File: tb/tb_spram_arbiter.sv
// Bench for spram_arbiter: RAM model attached, directed scenarios with
// literal expectations, then randomized traffic checked every cycle against
// a queue/array reference model of the arbitration and memory rules.
module tb_spram_arbiter;
  import spram_arb_pkg::*;

  localparam int N   = 3;
  localparam int AB  = 4;
  localparam int DEP = 1 << AB;
`ifdef SPRAM_ARB_CLEAR_EN
  localparam bit HAS_CLR  = 1'b1;
  localparam int INIT_CYC = DEP;
`else
  localparam bit HAS_CLR  = 1'b0;
  localparam int INIT_CYC = 1;
`endif

  logic                   clk, rst_n;
  logic [N-1:0]           req_valid, req_we, req_ready;
  logic [N-1:0][AB-1:0]   req_addr;
  logic [N-1:0][15:0][31:0] req_wdata;
  logic                   rsp_valid, init_done, ram_we;
  logic [1:0]             rsp_id;
  ram_word_t              rsp_data, ram_wdata, ram_rdata;
  logic [AB-1:0]          ram_addr;

  spram_arbiter #(.BIT_WIDTH(32), .RAM_WIDTH(16), .RAM_ADDR_BITS(AB), .N_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .init_done(init_done), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM macro model: registered read, rdata held during writes, preloaded to all ones.
  ram_word_t ram_mem [DEP] = '{default: '1};
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    else        ram_rdata <= ram_mem[ram_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int        m_ptr = 0, m_cnt = 0, m_last = 0, m_rsp_id = 0;
  bit        m_rsp_v = 1'b0;
  ram_word_t m_rsp_d;
  ram_word_t m_mem [DEP] = '{default: '1};
  int        e_win = -1, e_addr = 0, j;
  bit        e_we = 1'b0, e_clr = 1'b0;
  ram_word_t e_wdata;
  logic [N-1:0] exp_ready;
  bit   [N-1:0] h_pend = '0;
  logic [N-1:0] h_we;
  logic [N-1:0][AB-1:0] h_addr;
  logic [N-1:0][15:0][31:0] h_wd;

  always @(negedge clk) begin
    e_win = -1;
    e_clr = 1'b0;
    if (!rst_n) begin
      chk("rst_ready", 512'(req_ready), 512'(0));
      chk("rst_rsp_valid", 512'(rsp_valid), 512'(0));
      chk("rst_rsp_id", 512'(rsp_id), 512'(0));
      chk("rst_ram_we", 512'(ram_we), 512'(0));
      chk("rst_ram_addr", 512'(ram_addr), 512'(0));
      chk("rst_init_done", 512'(init_done), 512'(0));
      h_pend = '0;
    end else begin
      for (int i = 0; i < N; i++)
        if (h_pend[i])
          chk("hold", 512'(req_valid[i] && req_we[i] == h_we[i] && req_addr[i] == h_addr[i]
                           && req_wdata[i] == h_wd[i]), 512'(1));
      if (HAS_CLR && m_cnt < INIT_CYC) e_clr = 1'b1;
      else if (m_cnt >= INIT_CYC)
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (e_win < 0 && req_valid[j]) e_win = j;
        end
      exp_ready = (e_win >= 0) ? N'(1 << e_win) : '0;
      if (e_clr) begin
        e_we = 1'b1; e_addr = m_cnt; e_wdata = '0;
      end else if (e_win >= 0) begin
        e_we = req_we[e_win]; e_addr = int'(req_addr[e_win]); e_wdata = req_wdata[e_win];
      end else begin
        e_we = 1'b0; e_addr = m_last; e_wdata = '0;
      end
      chk("ready", 512'(req_ready), 512'(exp_ready));
      chk("init_done", 512'(init_done), 512'(m_cnt >= INIT_CYC));
      chk("ram_we", 512'(ram_we), 512'(e_we));
      chk("ram_addr", 512'(ram_addr), 512'(e_addr));
      if (e_we) chk("ram_wdata", ram_wdata, e_wdata);
      chk("rsp_valid", 512'(rsp_valid), 512'(m_rsp_v));
      if (m_rsp_v) begin
        chk("rsp_id", 512'(rsp_id), 512'(m_rsp_id));
        chk("rsp_data", rsp_data, m_rsp_d);
      end
      for (int i = 0; i < N; i++) h_pend[i] = req_valid[i] && (e_win != i);
      h_we = req_we; h_addr = req_addr; h_wd = req_wdata;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr = 0; m_cnt = 0; m_last = 0; m_rsp_v = 1'b0; m_rsp_id = 0;
    end else begin
      m_rsp_v = 1'b0;
      if (e_clr) m_mem[e_addr] = '0;
      else if (e_win >= 0) begin
        m_ptr = (e_win + 1) % N;
        if (e_we) m_mem[e_addr] = e_wdata;
        else begin
          m_rsp_v = 1'b1; m_rsp_id = e_win; m_rsp_d = m_mem[e_addr];
        end
      end
      m_last = e_addr;
      if (m_cnt < INIT_CYC) m_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  function automatic ram_word_t fill(input logic [31:0] d);
    ram_word_t w;
    for (int l = 0; l < 16; l++) w[l] = d;
    return w;
  endfunction

  function automatic ram_word_t rnd_word();
    ram_word_t w;
    for (int l = 0; l < 16; l++) w[l] = $urandom;
    return w;
  endfunction

  task automatic set_req(input int i, input bit v, input bit we, input int a, input ram_word_t d);
    req_valid[i] = v; req_we[i] = we; req_addr[i] = AB'(a); req_wdata[i] = d;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Called at posedge+1 with rst_n low; returns at posedge+1 after the first grant edge.
  task automatic release_rst(input logic [N-1:0] exp_gnt);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_init0", 512'(init_done), 512'(0));
    chk("rel_ready0", 512'(req_ready), 512'(0));
    repeat (INIT_CYC) step();
    @(negedge clk);
    chk("rel_init1", 512'(init_done), 512'(1));
    chk("rel_gnt", 512'(req_ready), 512'(exp_gnt));
    step();
  endtask

  ram_word_t    w;
  logic [N-1:0] acc;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; acc = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wdata", ram_wdata, '0);
    // Req0 pending through reset release: granted as soon as serving begins.
    set_req(0, 1, 0, 0, fill(0));
    release_rst(3'b001);
    set_req(0, 0, 0, 0, fill(0));

    if (HAS_CLR) begin
      for (int a = 0; a < DEP; a++) begin
        set_req(1, 1, 0, a, fill(0));
        step();
        chk("clr_rsp_v", 512'(rsp_valid), 512'(1));
        chk("clr_zero", rsp_data, '0);
      end
      set_req(1, 0, 0, 0, fill(0));
    end

    // Write then read the same address.
    set_req(0, 1, 1, 3, fill(32'hA5));
    @(negedge clk);
    chk("t1_wgnt", 512'(req_ready), 512'(3'b001));
    chk("t1_we", 512'(ram_we), 512'(1));
    chk("t1_addr", 512'(ram_addr), 512'(3));
    step();
    set_req(0, 1, 0, 3, fill(0));
    @(negedge clk);
    chk("t1_rgnt", 512'(req_ready), 512'(3'b001));
    step();
    set_req(0, 0, 0, 0, fill(0));
    @(negedge clk);
    w = rsp_data;
    chk("t1_rsp_v", 512'(rsp_valid), 512'(1));
    chk("t1_rsp_id", 512'(rsp_id), 512'(0));
    chk("t1_data0", 512'(w[0]), 512'(32'hA5));
    chk("t1_data15", 512'(w[15]), 512'(32'hA5));
    step();
    @(negedge clk);
    chk("idle_rsp_v", 512'(rsp_valid), 512'(0));
    step();

    // Pointer sits at 1 across idle cycles, so req2 beats req0.
    set_req(0, 1, 0, 1, fill(0));
    set_req(2, 1, 0, 2, fill(0));
    @(negedge clk);
    chk("ptr_hold", 512'(req_ready), 512'(3'b100));
    step();
    set_req(2, 0, 0, 0, fill(0));
    @(negedge clk);
    chk("ptr_next", 512'(req_ready), 512'(3'b001));
    chk("ptr_rsp_id", 512'(rsp_id), 512'(2));
    step();
    set_req(0, 0, 0, 0, fill(0));

    // req1 writes addr 5, req2 reads it back immediately.
    set_req(1, 1, 1, 5, fill(32'h5A5A_0001));
    @(negedge clk);
    chk("t3_wgnt", 512'(req_ready), 512'(3'b010));
    step();
    set_req(1, 0, 0, 0, fill(0));
    set_req(2, 1, 0, 5, fill(0));
    @(negedge clk);
    chk("t3_rgnt", 512'(req_ready), 512'(3'b100));
    chk("t3_after_wr", 512'(rsp_valid), 512'(0));
    step();
    set_req(2, 0, 0, 0, fill(0));
    @(negedge clk);
    w = rsp_data;
    chk("t3_rsp_id", 512'(rsp_id), 512'(2));
    chk("t3_data", 512'(w[0]), 512'(32'h5A5A_0001));
    step();
    @(negedge clk);
    chk("t3_idle", 512'(rsp_valid), 512'(0));
    step();

    // All three read continuously: grants rotate 0,1,2,...
    for (int i = 0; i < N; i++) set_req(i, 1, 0, i, fill(0));
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk("rr_gnt", 512'(req_ready), 512'(1 << (k % 3)));
      if (k >= 1) chk("rr_rsp_id", 512'(rsp_id), 512'((k - 1) % 3));
      step();
      if (k >= 6) set_req(k % 3, 0, 0, 0, fill(0));
    end
    @(negedge clk);
    chk("rr_last_id", 512'(rsp_id), 512'(2));
    step();

    // Reset in the cycle after a read accept.
    set_req(0, 1, 0, 3, fill(0));
    @(negedge clk);
    chk("t4_gnt", 512'(req_ready), 512'(3'b001));
    step();
    chk("t4_rsp_pre", 512'(rsp_valid), 512'(1));
    rst_n = 1'b0;
    set_req(2, 1, 0, 7, fill(0));
    #1;
    chk("t4_rsp_kill", 512'(rsp_valid), 512'(0));
    chk("t4_ready0", 512'(req_ready), 512'(0));
    step();
    step();
    // rr_ptr back at 0: req0 wins over req2.
    release_rst(3'b001);
    set_req(0, 0, 0, 0, fill(0));
    @(negedge clk);
    chk("t4_req2", 512'(req_ready), 512'(3'b100));
    step();
    set_req(2, 0, 0, 0, fill(0));

    // Random traffic; a requester changes its request only when idle or accepted.
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      step();
      for (int i = 0; i < N; i++)
        if (!req_valid[i] || acc[i]) begin
          if ($urandom_range(2) != 0)
            set_req(i, 1, 1'($urandom_range(1)),
                    ($urandom_range(3) == 0) ? int'($urandom_range(DEP - 1)) : int'($urandom_range(3)),
                    rnd_word());
          else
            req_valid[i] = 1'b0;
        end
    end
    for (int c = 0; c < 20 && (|req_valid); c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      step();
      req_valid = req_valid & ~acc;
    end
    chk("drain", 512'(req_valid), 512'(0));
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
